// File: rtl/vga_timing.sv
// 640x480@60 VGA pixel timing generator on clk_50, with clk_25 sampled as data for a pixel enable.
// Define VGA_TEST_PATTERN_EN to drive rgb with an eight-bar colour pattern; otherwise rgb is tied to zero.
module vga_timing #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             clk_25,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [11:0]      rgb
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_param_check
      $error("vga_timing: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_FINAL = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_FINAL = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ACT  = (SYNC_POL != 0);
  localparam logic             SYNC_IDLE = !SYNC_ACT;

  logic             clk_25_q;
  logic             pix_ce;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q;
  logic             frame_start_q;

  assign pix_ce = clk_25 & ~clk_25_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Decode from the next counter values so registered flags line up with x/y.
  always_comb begin
    hsync_d    = (x_d >= HS_FIRST && x_d <= HS_FINAL) ? SYNC_ACT : SYNC_IDLE;
    vsync_d    = (y_d >= VS_FIRST && y_d <= VS_FINAL) ? SYNC_ACT : SYNC_IDLE;
    video_on_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      clk_25_q      <= 1'b0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      clk_25_q      <= clk_25;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_ce) begin
        x_q           <= x_d;
        y_q           <= y_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        video_on_q    <= video_on_d;
        line_start_q  <= (x_d == '0);
        frame_start_q <= (x_d == '0) && (y_d == '0);
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_VIS / 8);

  logic [CNT_W-1:0] bar_idx;
  logic [11:0]      bar_rgb;
  logic [11:0]      rgb_q;

  always_comb begin
    bar_idx = x_d / BAR_W;
    case (bar_idx)
      CNT_W'(0): bar_rgb = 12'hFFF;
      CNT_W'(1): bar_rgb = 12'hFF0;
      CNT_W'(2): bar_rgb = 12'h0FF;
      CNT_W'(3): bar_rgb = 12'h0F0;
      CNT_W'(4): bar_rgb = 12'hF0F;
      CNT_W'(5): bar_rgb = 12'hF00;
      CNT_W'(6): bar_rgb = 12'h00F;
      default:   bar_rgb = 12'h000;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      rgb_q <= 12'h000;
    end else if (pix_ce) begin
      rgb_q <= video_on_d ? bar_rgb : 12'h000;
    end
  end

  assign rgb = rgb_q;
`else
  assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a shrunken raster so whole frames fit in a short run.
// Reference model tracks a linear pixel index within the frame and derives x/y/flags arithmetically.
module tb_vga_timing;
  localparam int H_VIS = 64, H_FP = 8, H_SYNC = 12, H_BP = 12;
  localparam int V_VIS = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int SYNC_POL = 0, CNT_W = 7;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;  // 96
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;  // 17
  localparam int FRAME = HT * VT;
  localparam logic S_ACT = (SYNC_POL != 0);
  localparam logic S_IDLE = !S_ACT;

  logic             clk_50 = 1'b0;
  logic             reset_n = 1'b0;
  logic             clk_25 = 1'b0;
  logic             hsync, vsync, video_on, line_start, frame_start;
  logic [CNT_W-1:0] x, y;
  logic [11:0]      rgb;

  int n_checks = 0;
  int n_fail = 0;

  always #10 clk_50 = ~clk_50;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .clk_25(clk_25),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .rgb(rgb)
  );

  // ---------------- reference model ----------------
  int          m_pix;
  logic        m_prev;
  logic        m_hs, m_vs, m_vo, m_ls, m_fs;
  logic [11:0] m_rgb;
  int          np, nx, ny;

  function automatic logic [11:0] bar_colour(input int xx);
    logic [11:0] table_c [8];
    table_c = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return table_c[xx / (H_VIS / 8)];
  endfunction

  always @(posedge clk_50) begin
    if (!reset_n) begin
      m_pix <= FRAME - 1;
      m_prev <= 1'b0;
      m_hs <= S_IDLE; m_vs <= S_IDLE; m_vo <= 1'b0;
      m_ls <= 1'b0; m_fs <= 1'b0; m_rgb <= 12'h000;
    end else begin
      m_prev <= clk_25;
      m_ls <= 1'b0;
      m_fs <= 1'b0;
      if (clk_25 && !m_prev) begin
        np = (m_pix + 1) % FRAME;
        nx = np % HT;
        ny = np / HT;
        m_pix <= np;
        m_hs <= (nx >= H_VIS + H_FP && nx <= H_VIS + H_FP + H_SYNC - 1) ? S_ACT : S_IDLE;
        m_vs <= (ny >= V_VIS + V_FP && ny <= V_VIS + V_FP + V_SYNC - 1) ? S_ACT : S_IDLE;
        m_vo <= (nx < H_VIS) && (ny < V_VIS);
        m_ls <= (nx == 0);
        m_fs <= (np == 0);
`ifdef VGA_TEST_PATTERN_EN
        m_rgb <= ((nx < H_VIS) && (ny < V_VIS)) ? bar_colour(nx) : 12'h000;
`else
        m_rgb <= 12'h000;
`endif
      end
    end
  end

  logic [30:0] act_vec, exp_vec, rst_vec;
  assign act_vec = {hsync, vsync, video_on, line_start, frame_start, x, y, rgb};
  assign exp_vec = {m_hs, m_vs, m_vo, m_ls, m_fs, CNT_W'(m_pix % HT), CNT_W'(m_pix / HT), m_rgb};
  assign rst_vec = {S_IDLE, S_IDLE, 3'b000, CNT_W'(HT - 1), CNT_W'(VT - 1), 12'h000};

  task automatic step(input logic c25, input logic rn);
    clk_25 = c25;
    reset_n = rn;
    @(posedge clk_50);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(!clk_25, 1'b0);
      n_checks++;
      if (act_vec !== rst_vec) begin
        n_fail++;
        $display("FAIL reset_values cyc %0d: got %h need %h", i, act_vec, rst_vec);
      end
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (act_vec !== rst_vec) begin
      n_fail++;
      $display("FAIL reset_hold_no_ce: got %h need %h", act_vec, rst_vec);
    end
    step(1'b1, 1'b1);
    n_checks++;
    if ({x, y, video_on, line_start, frame_start} !== {CNT_W'(0), CNT_W'(0), 3'b111}) begin
      n_fail++;
      $display("FAIL first_ce_wrap: got x=%0d y=%0d vo=%b ls=%b fs=%b need 0 0 1 1 1",
               x, y, video_on, line_start, frame_start);
    end
    step(1'b0, 1'b1);
    n_checks++;
    if ({x, line_start, frame_start, video_on} !== {CNT_W'(0), 3'b001}) begin
      n_fail++;
      $display("FAIL pulse_width: got x=%0d ls=%b fs=%b vo=%b need x=0 ls=0 fs=0 vo=1",
               x, line_start, frame_start, video_on);
    end
  endtask

  task automatic test_cadence();
    int x0, adv;
    x0 = int'(x);
    for (int i = 0; i < 40; i++) begin
      step(!clk_25, 1'b1);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL cadence_model cyc %0d: got %h need %h", i, act_vec, exp_vec);
      end
    end
    adv = (int'(x) - x0 + HT) % HT;
    n_checks++;
    if (adv != 20) begin
      n_fail++;
      $display("FAIL cadence_advance: got %0d pixels need 20", adv);
    end
    step(1'b1, 1'b1);
    x0 = int'(x);
    adv = int'(y);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    n_checks++;
    if (int'(x) != x0 || int'(y) != adv) begin
      n_fail++;
      $display("FAIL freeze: got x=%0d y=%0d need x=%0d y=%0d", x, y, x0, adv);
    end
  endtask

  task automatic test_horizontal();
    int guard, hs_cnt, vo_cnt, period;
    guard = 0;
    while (!line_start && guard < 4 * HT) begin step(!clk_25, 1'b1); guard++; end
    n_checks++;
    if (!line_start) begin
      n_fail++;
      $display("FAIL line_start_timeout: got none need pulse within %0d cycles", 4 * HT);
    end
    hs_cnt = 0; vo_cnt = 0; period = 0;
    do begin
      step(!clk_25, 1'b1);
      period++;
      if (hsync == S_ACT) hs_cnt++;
      if (video_on) vo_cnt++;
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL horiz_model x=%0d y=%0d: got %h need %h", x, y, act_vec, exp_vec);
      end
    end while (!line_start && period < 4 * HT);
    n_checks++;
    if (period != 2 * HT) begin
      n_fail++;
      $display("FAIL line_period: got %0d cycles need %0d", period, 2 * HT);
    end
    n_checks++;
    if (hs_cnt != 2 * H_SYNC) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d cycles need %0d", hs_cnt, 2 * H_SYNC);
    end
    n_checks++;
    if (vo_cnt != 2 * H_VIS) begin
      n_fail++;
      $display("FAIL video_on_width: got %0d cycles need %0d", vo_cnt, 2 * H_VIS);
    end
  endtask

  task automatic test_frame();
    int guard, period, vs_cnt;
    guard = 0;
    while (!frame_start && guard < 3 * FRAME) begin step(!clk_25, 1'b1); guard++; end
    n_checks++;
    if (!frame_start) begin
      n_fail++;
      $display("FAIL frame_start_timeout: got none need pulse within %0d cycles", 3 * FRAME);
    end
    period = 0; vs_cnt = 0;
    do begin
      step(!clk_25, 1'b1);
      period++;
      if (vsync == S_ACT) vs_cnt++;
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL frame_model x=%0d y=%0d: got %h need %h", x, y, act_vec, exp_vec);
      end
    end while (!frame_start && period < 3 * FRAME);
    n_checks++;
    if (period != 2 * FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d cycles need %0d", period, 2 * FRAME);
    end
    n_checks++;
    if (vs_cnt != 2 * V_SYNC * HT) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d cycles need %0d", vs_cnt, 2 * V_SYNC * HT);
    end
  endtask

  task automatic test_mid_reset();
    int guard, period;
    guard = 0;
    while (!(x == CNT_W'(30) && y == CNT_W'(5)) && guard < 3 * FRAME) begin
      step(!clk_25, 1'b1); guard++;
    end
    step(!clk_25, 1'b0);
    n_checks++;
    if (act_vec !== rst_vec) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %h need %h", act_vec, rst_vec);
    end
    guard = 0;
    do begin step(!clk_25, 1'b1); guard++; end while (!frame_start && guard < 8);
    n_checks++;
    if ({x, y, frame_start} !== {CNT_W'(0), CNT_W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got x=%0d y=%0d fs=%b need 0 0 1", x, y, frame_start);
    end
    period = 0;
    do begin
      step(!clk_25, 1'b1);
      period++;
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL mid_reset_model x=%0d y=%0d: got %h need %h", x, y, act_vec, exp_vec);
      end
    end while (!line_start && period < 4 * HT);
    n_checks++;
    if (period != 2 * HT) begin
      n_fail++;
      $display("FAIL mid_reset_first_line: got %0d cycles need %0d", period, 2 * HT);
    end
  endtask

  task automatic test_pattern();
    int guard;
    guard = 0;
    while (!frame_start && guard < 3 * FRAME) begin step(!clk_25, 1'b1); guard++; end
`ifdef VGA_TEST_PATTERN_EN
    for (int i = 0; i < 2 * HT; i++) begin
      logic [11:0] want;
      int xi;
      xi = int'(x);
      want = (xi < 8) ? 12'hFFF : (xi < 16) ? 12'hFF0 : (xi < 24) ? 12'h0FF : (xi < 32) ? 12'h0F0 :
             (xi < 40) ? 12'hF0F : (xi < 48) ? 12'hF00 : (xi < 56) ? 12'h00F : 12'h000;
      n_checks++;
      if (rgb !== want) begin
        n_fail++;
        $display("FAIL pattern_bar x=%0d: got %h need %h", x, rgb, want);
      end
      step(!clk_25, 1'b1);
    end
`else
    for (int i = 0; i < 2 * FRAME; i++) begin
      n_checks++;
      if (rgb !== 12'h000) begin
        n_fail++;
        $display("FAIL rgb_tied x=%0d y=%0d: got %h need 000", x, y, rgb);
      end
      step(!clk_25, 1'b1);
    end
`endif
  endtask

  task automatic test_random();
    logic c25, rn;
    for (int i = 0; i < 6000; i++) begin
      c25 = ($urandom_range(0, 3) != 0) ? !clk_25 : clk_25;
      rn  = ($urandom_range(0, 499) != 0);
      step(c25, rn);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_model cyc %0d x=%0d y=%0d: got %h need %h", i, x, y, act_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_horizontal();
    test_frame();
    test_mid_reset();
    test_pattern();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
